// File: rtl/wb_host_arb_pkg.sv
// wb_host_arbiter shared types: FSM states, one-hot grant codes,
// default error read data and a saturating counter helper.
package wb_host_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TERM  = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_host_arbiter_if.sv
// Bus bundle for wb_host_arbiter: two Wishbone masters, one slave.
// 'slave' is the arbiter's view, 'master' the environment's view.
interface wb_host_arbiter_if;

  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;

  logic [1:0]  grant_o;
  logic        timeout_o;
  logic [7:0]  err_count_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i,
    input  m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_ack_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_ack_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i,
    output grant_o, timeout_o, err_count_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i,
    output m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_ack_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i,
    output m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_ack_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i,
    input  grant_o, timeout_o, err_count_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Two-way round-robin pick: on contention the master that
// was not granted last wins. last_i=1 means m1 was last.
module wb_rr_pick
  import wb_host_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // pure combinational pick
  always_comb begin
    gnt_o = GNT_NONE;
    unique case (1'b1)
      (req_i == 2'b11):  gnt_o = last_i ? GNT_M0 : GNT_M1;
      (req_i == GNT_M0): gnt_o = GNT_M0;
      (req_i == GNT_M1): gnt_o = GNT_M1;
      default:           gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_host_arbiter.sv
// Two-master Wishbone B4 round-robin arbiter, grant held per cyc.
// Optional ack watchdog enabled by `define WB_HOST_ARB_TIMEOUT_EN.
module wb_host_arbiter
  import wb_host_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_host_arbiter_if.slave  bus
);

  arb_state_e  state_q, state_d, st;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  pick;
  logic        last_q, last_d;

  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;

  logic        busy;
  logic        s_cyc, s_stb;
  logic        ack;
  logic [31:0] rdat;
  logic        tmo;

`ifdef WB_HOST_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 16'(TIMEOUT_CYCLES)};
`endif

  wb_rr_pick u_pick (
    .req_i  ({bus.m1_cyc_i, bus.m0_cyc_i}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // reset forces idle outputs in the same cycle
  assign st   = wb_rst_ni ? state_q : IDLE;
  assign busy = (st != IDLE);

  // request mux from the granted master
  always_comb begin
    if (grant_q[1]) begin
      g_cyc = bus.m1_cyc_i;
      g_stb = bus.m1_stb_i;
      g_we  = bus.m1_we_i;
      g_adr = bus.m1_adr_i;
      g_dat = bus.m1_dat_i;
      g_sel = bus.m1_sel_i;
    end else begin
      g_cyc = bus.m0_cyc_i;
      g_stb = bus.m0_stb_i;
      g_we  = bus.m0_we_i;
      g_adr = bus.m0_adr_i;
      g_dat = bus.m0_dat_i;
      g_sel = bus.m0_sel_i;
    end
  end

  // next state, grant bookkeeping and bus strobes
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    ack     = 1'b0;
    rdat    = '0;
    tmo     = 1'b0;
`ifdef WB_HOST_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (st)
      IDLE: begin
        if (|pick) begin
          state_d = GRANT;
          grant_d = pick;
        end
`ifdef WB_HOST_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      GRANT: begin
        s_cyc = g_cyc;
        s_stb = g_cyc & g_stb;
        ack   = s_stb & bus.s_ack_i;
        rdat  = ack ? bus.s_dat_i : '0;
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
          last_d  = grant_q[1];
        end
`ifdef WB_HOST_ARB_TIMEOUT_EN
        if (!s_stb || bus.s_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          state_d = TERM;
          err_d   = sat_inc8(err_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
`ifdef WB_HOST_ARB_TIMEOUT_EN
      TERM: begin
        ack  = 1'b1;
        rdat = ERR_DATA;
        tmo  = 1'b1;
        if (g_cyc) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
          grant_d = GNT_NONE;
          last_d  = grant_q[1];
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // arbitration state registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_HOST_ARB_TIMEOUT_EN
  // watchdog counter and timeout tally
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err_count_o = err_q;
`else
  assign bus.err_count_o = '0;
`endif

  assign bus.timeout_o = tmo;
  assign bus.grant_o   = busy ? grant_q : GNT_NONE;

  assign bus.s_cyc_o = s_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = busy & g_we;
  assign bus.s_adr_o = busy ? g_adr : '0;
  assign bus.s_dat_o = busy ? g_dat : '0;
  assign bus.s_sel_o = busy ? g_sel : '0;

  assign bus.m0_ack_o = ack & grant_q[0];
  assign bus.m0_dat_o = grant_q[0] ? rdat : '0;
  assign bus.m1_ack_o = ack & grant_q[1];
  assign bus.m1_dat_o = grant_q[1] ? rdat : '0;

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Directed bench for wb_host_arbiter: vector table plus
// hand-written burst, watchdog and reset sequences.
module tb_wb_host_arbiter;

  localparam int TMO = 8;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] W0 = 32'h0000_00A0;
  localparam logic [31:0] W1 = 32'h0000_00B1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  wb_host_arbiter_if bus();

  wb_host_arbiter #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        scyc;
    logic        sstb;
    logic        swe;
    logic [31:0] sadr;
    logic [31:0] swdat;
    logic [3:0]  ssel;
    logic        m0ack;
    logic [31:0] m0dat;
    logic        m1ack;
    logic [31:0] m1dat;
    logic        tmo;
    logic [7:0]  errc;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        c0;
    logic        s0;
    logic        c1;
    logic        s1;
    logic        ack;
    logic [31:0] sdat;
  } in_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vt [16];

  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_g(
    input logic [1:0]  g,
    input logic        cyc,
    input logic        stb,
    input logic        a,
    input logic [31:0] rd
  );
    out_t o = '0;
    o.gnt  = g;
    o.scyc = cyc;
    o.sstb = stb;
    if (g == 2'b01) begin
      o.sadr  = A0;
      o.swdat = W0;
      o.ssel  = 4'hF;
      o.swe   = 1'b0;
      o.m0ack = a;
      o.m0dat = a ? rd : 32'h0;
    end else begin
      o.sadr  = A1;
      o.swdat = W1;
      o.ssel  = 4'h3;
      o.swe   = 1'b1;
      o.m1ack = a;
      o.m1dat = a ? rd : 32'h0;
    end
    return o;
  endfunction

  function automatic in_t mk(
    input logic r, input logic c0, input logic s0,
    input logic c1, input logic s1, input logic a,
    input logic [31:0] d
  );
    in_t v;
    v.rst  = r;
    v.c0   = c0;
    v.s0   = s0;
    v.c1   = c1;
    v.s1   = s1;
    v.ack  = a;
    v.sdat = d;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.gnt   = bus.grant_o;
    o.scyc  = bus.s_cyc_o;
    o.sstb  = bus.s_stb_o;
    o.swe   = bus.s_we_o;
    o.sadr  = bus.s_adr_o;
    o.swdat = bus.s_dat_o;
    o.ssel  = bus.s_sel_o;
    o.m0ack = bus.m0_ack_o;
    o.m0dat = bus.m0_dat_o;
    o.m1ack = bus.m1_ack_o;
    o.m1dat = bus.m1_dat_o;
    o.tmo   = bus.timeout_o;
    o.errc  = bus.err_count_o;
    return o;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst_n          = v.rst;
    bus.m0_cyc_i   = v.c0;
    bus.m0_stb_i   = v.s0;
    bus.m1_cyc_i   = v.c1;
    bus.m1_stb_i   = v.s1;
    bus.s_ack_i    = v.ack;
    bus.s_dat_i    = v.sdat;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int pulses;
    int bad;
    bus.m0_cyc_i = 1'b0;
    bus.m0_stb_i = 1'b0;
    bus.m0_we_i  = 1'b0;
    bus.m0_adr_i = A0;
    bus.m0_dat_i = W0;
    bus.m0_sel_i = 4'hF;
    bus.m1_cyc_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    bus.m1_we_i  = 1'b1;
    bus.m1_adr_i = A1;
    bus.m1_dat_i = W1;
    bus.m1_sel_i = 4'h3;
    bus.s_ack_i  = 1'b0;
    bus.s_dat_i  = '0;

    vt[0]  = '{mk(0,1,1,1,1,0,0), o_idle()};
    vt[1]  = '{mk(0,1,1,1,1,0,0), o_idle()};
    vt[2]  = '{mk(0,1,1,1,1,0,0), o_idle()};
    vt[3]  = '{mk(1,1,1,1,1,0,0), o_idle()};
    vt[4]  = '{mk(1,1,1,1,1,0,0),
               o_g(2'b01,1,1,0,0)};
    vt[5]  = '{mk(1,1,1,1,1,1,32'h1234_5678),
               o_g(2'b01,1,1,1,32'h1234_5678)};
    vt[6]  = '{mk(1,0,0,1,1,0,0),
               o_g(2'b01,0,0,0,0)};
    vt[7]  = '{mk(1,1,1,1,1,0,0), o_idle()};
    vt[8]  = '{mk(1,1,1,1,1,0,0),
               o_g(2'b10,1,1,0,0)};
    vt[9]  = '{mk(1,1,1,1,1,1,32'hA5A5_0001),
               o_g(2'b10,1,1,1,32'hA5A5_0001)};
    vt[10] = '{mk(1,1,1,0,0,0,0),
               o_g(2'b10,0,0,0,0)};
    vt[11] = '{mk(1,1,1,1,1,0,0), o_idle()};
    vt[12] = '{mk(1,1,1,1,1,1,32'hCAFE_0003),
               o_g(2'b01,1,1,1,32'hCAFE_0003)};
    vt[13] = '{mk(1,1,0,1,1,1,32'h0000_0077),
               o_g(2'b01,1,0,0,0)};
    vt[14] = '{mk(1,0,0,1,1,0,0),
               o_g(2'b01,0,0,0,0)};
    vt[15] = '{mk(1,0,0,0,0,0,0), o_idle()};

    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #1;
      drive(vt[n].i);
      @(negedge clk);
      chk_out($sformatf("vec%0d", n), vt[n].o);
    end

    // locked burst: m1 wins (m0 was last), m0 waits
    next();
    bus.m1_adr_i = 32'h3000_0000;
    bus.m1_cyc_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    bus.m0_cyc_i = 1'b1;
    bus.m0_stb_i = 1'b1;
    @(negedge clk);
    chk("burst idle gnt", 32'(bus.grant_o), 32'h0);
    for (int b = 0; b < 4; b++) begin
      next();
      bus.m1_adr_i = 32'h3000_0000 + 32'(4 * b);
      bus.s_ack_i  = 1'b1;
      bus.s_dat_i  = '0;
      @(negedge clk);
      chk("burst gnt", 32'(bus.grant_o), 32'h2);
      chk("burst adr", bus.s_adr_o,
          32'h3000_0000 + 32'(4 * b));
      chk("burst m1 ack", 32'(bus.m1_ack_o), 32'h1);
      chk("burst m0 ack", 32'(bus.m0_ack_o), 32'h0);
    end
    next();
    bus.m1_cyc_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    bus.s_ack_i  = 1'b0;
    @(negedge clk);
    chk("burst end m0 ack", 32'(bus.m0_ack_o), 32'h0);
    chk("burst end s_cyc", 32'(bus.s_cyc_o), 32'h0);
    next();
    @(negedge clk);
    chk("handover idle", 32'(bus.grant_o), 32'h0);
    next();
    @(negedge clk);
    chk("handover gnt m0", 32'(bus.grant_o), 32'h1);
    chk("handover adr", bus.s_adr_o, A0);

    // m0 now holds stb with no ack (cycle K above)
`ifdef WB_HOST_ARB_TIMEOUT_EN
    bad = 0;
    for (int k = 1; k < TMO; k++) begin
      next();
      @(negedge clk);
      if (bus.timeout_o || bus.m0_ack_o || !bus.s_stb_o)
        bad++;
    end
    chk("pre-term quiet cycles", 32'(bad), 32'h0);
    next();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1111_2222;
    @(negedge clk);
    chk("term timeout_o", 32'(bus.timeout_o), 32'h1);
    chk("term m0 ack", 32'(bus.m0_ack_o), 32'h1);
    chk("term m0 dat", bus.m0_dat_o, 32'hDEAD_BEEF);
    chk("term s_stb", 32'(bus.s_stb_o), 32'h0);
    chk("term s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("term m1 ack", 32'(bus.m1_ack_o), 32'h0);
    next();
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    @(negedge clk);
    chk("post-term timeout_o", 32'(bus.timeout_o), 32'h0);
    chk("post-term err", 32'(bus.err_count_o), 32'h1);
    chk("post-term gnt", 32'(bus.grant_o), 32'h1);
    pulses = 0;
    for (int c = 0; c < 4000 && pulses < 299; c++) begin
      @(negedge clk);
      if (bus.timeout_o) pulses++;
    end
    chk("timeout pulses", 32'(pulses), 32'd299);
    chk("err saturate", 32'(bus.err_count_o), 32'd255);
`else
    bad = 0;
    for (int k = 1; k < 3 * TMO; k++) begin
      next();
      @(negedge clk);
      if (bus.timeout_o || bus.m0_ack_o ||
          bus.grant_o != 2'b01 || bus.err_count_o != 8'd0)
        bad++;
    end
    chk("hung slave holds", 32'(bad), 32'h0);
`endif
    next();
    bus.m0_cyc_i = 1'b0;
    bus.m0_stb_i = 1'b0;
    next();
    @(negedge clk);
    chk("drop idle gnt", 32'(bus.grant_o), 32'h0);

    // reset during m1 beat 2 of 4
    next();
    bus.m1_adr_i = 32'h3000_0000;
    bus.m1_cyc_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    @(negedge clk);
    chk("rst seq idle", 32'(bus.grant_o), 32'h0);
    next();
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("rst seq beat1 ack", 32'(bus.m1_ack_o), 32'h1);
    next();
    bus.m1_adr_i = 32'h3000_0004;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst beat2 no ack", 32'(bus.m1_ack_o), 32'h0);
    next();
    rst_n = 1'b1;
    bus.m0_cyc_i = 1'b1;
    bus.m0_stb_i = 1'b1;
    @(negedge clk);
    chk("after rst gnt", 32'(bus.grant_o), 32'h0);
    chk("after rst m1 ack", 32'(bus.m1_ack_o), 32'h0);
    chk("after rst s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("after rst err", 32'(bus.err_count_o), 32'h0);
    next();
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    chk("after rst m0 first", 32'(bus.grant_o), 32'h1);

    next();
    bus.m0_cyc_i = 1'b0;
    bus.m0_stb_i = 1'b0;
    bus.m1_cyc_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
